// File: rtl/mem_responder_if.sv
// Request/response bus between a memory initiator and mem_responder.
// The master side issues requests; the slave side returns read data and a completion pulse.
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_wdata,
        output mem_byte_enable,
        input  mem_rdata,
        input  mem_resp
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_wdata,
        input  mem_byte_enable,
        output mem_rdata,
        output mem_resp
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory responder: captures one request in IDLE, waits LATENCY cycles,
// then pulses mem_resp for one cycle. Writes commit at the edge that ends the response cycle.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             is_write_q, is_write_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      mem_q [DEPTH_WORDS];

    logic [AW-1:0]    req_idx;
    logic             unused_addr_bits;

    // Byte-offset bits and bits above the array size alias onto the same words.
    assign req_idx          = bus.mem_address[AW+1:2];
    assign unused_addr_bits = ^{bus.mem_address[31:AW+2], bus.mem_address[1:0]};

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        is_write_d = is_write_q;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    idx_d      = req_idx;
                    wdata_d    = bus.mem_wdata;
                    be_d       = bus.mem_byte_enable;
                    is_write_d = bus.mem_write;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        if (!bus.mem_write) begin
                            rdata_d = mem_q[req_idx];
                        end
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (!is_write_q) begin
                        rdata_d = mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
        end
    end

    // NOTE: the storage array has no reset; contents survive rst, only the commit is gated by it.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RESP && is_write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_resp  = (state_q == RESP);
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (LATENCY 1, 2, 5) share stimulus through a
// selector; each step checks response latency, pulse width and returned data.
module tb_mem_responder;
    logic        clk;
    logic        rst;
    int          sel;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        resp_o;
    logic [31:0] rdata_o;

    int total;
    int bad;

    mem_responder_if if_l1 ();
    mem_responder_if if_l2 ();
    mem_responder_if if_l5 ();

    assign if_l1.mem_read        = (sel == 0) && rd;
    assign if_l1.mem_write       = (sel == 0) && wr;
    assign if_l1.mem_address     = addr;
    assign if_l1.mem_wdata       = wdata;
    assign if_l1.mem_byte_enable = be;
    assign if_l2.mem_read        = (sel == 1) && rd;
    assign if_l2.mem_write       = (sel == 1) && wr;
    assign if_l2.mem_address     = addr;
    assign if_l2.mem_wdata       = wdata;
    assign if_l2.mem_byte_enable = be;
    assign if_l5.mem_read        = (sel == 2) && rd;
    assign if_l5.mem_write       = (sel == 2) && wr;
    assign if_l5.mem_address     = addr;
    assign if_l5.mem_wdata       = wdata;
    assign if_l5.mem_byte_enable = be;

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_l1 (.clk(clk), .rst(rst), .bus(if_l1));
    mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut_l2 (.clk(clk), .rst(rst), .bus(if_l2));
    mem_responder #(.DEPTH_WORDS(256), .LATENCY(5)) u_dut_l5 (.clk(clk), .rst(rst), .bus(if_l5));

    always_comb begin
        resp_o  = if_l2.mem_resp;
        rdata_o = if_l2.mem_rdata;
        case (sel)
            0: begin
                resp_o  = if_l1.mem_resp;
                rdata_o = if_l1.mem_rdata;
            end
            2: begin
                resp_o  = if_l5.mem_resp;
                rdata_o = if_l5.mem_rdata;
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request held for a single sampling edge; reports negedges until mem_resp, the data seen
    // in that cycle, and mem_resp one cycle later.
    task automatic txn(input int s, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       output int lat, output logic [31:0] rd_data, output logic resp_after);
        @(negedge clk);
        sel   = s;
        rd    = r;
        wr    = w;
        addr  = a;
        wdata = d;
        be    = b;
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
        lat        = -1;
        rd_data    = 'x;
        resp_after = 1'bx;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (resp_o === 1'b1) begin
                lat     = n;
                rd_data = rdata_o;
                break;
            end
        end
        @(negedge clk);
        resp_after = resp_o;
    endtask

    initial begin
        int          lat;
        logic [31:0] d;
        logic        ra;
        logic [8:0]  pattern;
        logic [31:0] b2b_data;
        logic        seen;

        total = 0;
        bad   = 0;
        sel   = 1;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        be    = '0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_resp_l2", {31'b0, if_l2.mem_resp}, 32'h0);
        check("reset_rdata_l2", if_l2.mem_rdata, 32'h0);
        check("reset_resp_l1", {31'b0, if_l1.mem_resp}, 32'h0);
        check("reset_rdata_l5", if_l5.mem_rdata, 32'h0);
        rst = 1'b0;

        // Full-word write then read, LATENCY=2
        txn(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, d, ra);
        check("wr10_latency", lat, 2);
        check("wr10_pulse_width", {31'b0, ra}, 32'h0);
        check("wr10_rdata_unchanged", d, 32'h0);
        txn(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, d, ra);
        check("rd10_latency", lat, 2);
        check("rd10_data", d, 32'hDEADBEEF);
        check("rd10_pulse_width", {31'b0, ra}, 32'h0);

        // Partial byte-enable merge
        txn(1, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, d, ra);
        txn(1, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, d, ra);
        check("wr20_be_rdata_unchanged", d, 32'hDEADBEEF);
        txn(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, d, ra);
        check("rd20_merged", d, 32'h11BB33DD);

        // Address wrap and ignored byte offset
        txn(1, 1'b0, 1'b1, 32'h400, 32'h5A5A5A5A, 4'hF, lat, d, ra);
        txn(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, d, ra);
        check("rd0_wrap", d, 32'h5A5A5A5A);
        txn(1, 1'b1, 1'b0, 32'h3, 32'h0, 4'h0, lat, d, ra);
        check("rd3_low_bits", d, 32'h5A5A5A5A);

        // Zero byte-enable write leaves storage alone
        txn(1, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, lat, d, ra);
        check("wr_be0_latency", lat, 2);
        txn(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, d, ra);
        check("rd20_after_be0", d, 32'h11BB33DD);

        // Read and write both high behaves as a write
        txn(1, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, lat, d, ra);
        check("rdwr_rdata_unchanged", d, 32'h11BB33DD);
        txn(1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, lat, d, ra);
        check("rd30_after_rdwr", d, 32'hCAFEF00D);

        // Read held high: pulses at negedges 2, 5, 8 after the first sample
        @(negedge clk);
        sel      = 1;
        rd       = 1'b1;
        wr       = 1'b0;
        addr     = 32'h10;
        pattern  = '0;
        b2b_data = '0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            pattern[i] = resp_o;
            if (resp_o === 1'b1) b2b_data = rdata_o;
        end
        rd = 1'b0;
        check("b2b_pulse_pattern", {23'b0, pattern}, {23'b0, 9'b010010010});
        check("b2b_data", b2b_data, 32'hDEADBEEF);
        repeat (3) @(negedge clk);

        // Reset during WAIT aborts a write; a request during reset is ignored
        txn(1, 1'b0, 1'b1, 32'h8, 32'h00000077, 4'hF, lat, d, ra);
        @(negedge clk);
        sel   = 1;
        wr    = 1'b1;
        addr  = 32'h8;
        wdata = 32'h00000001;
        be    = 4'hF;
        @(posedge clk);
        #1;
        wr = 1'b0;
        @(negedge clk);
        check("abort_wait_no_resp", {31'b0, resp_o}, 32'h0);
        rst  = 1'b1;
        rd   = 1'b1;
        addr = 32'h8;
        @(negedge clk);
        check("abort_rst_resp", {31'b0, resp_o}, 32'h0);
        check("abort_rst_rdata", rdata_o, 32'h0);
        rst  = 1'b0;
        rd   = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | resp_o;
        end
        check("abort_no_late_resp", {31'b0, seen}, 32'h0);
        txn(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, lat, d, ra);
        check("abort_rd8_latency", lat, 2);
        check("abort_rd8_prior", d, 32'h00000077);

        // LATENCY=1 instance
        txn(0, 1'b0, 1'b1, 32'h4, 32'h0BADF00D, 4'hF, lat, d, ra);
        check("l1_wr_latency", lat, 1);
        check("l1_wr_pulse_width", {31'b0, ra}, 32'h0);
        txn(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, lat, d, ra);
        check("l1_rd_latency", lat, 1);
        check("l1_rd_data", d, 32'h0BADF00D);
        txn(0, 1'b1, 1'b1, 32'h4, 32'h12345678, 4'hF, lat, d, ra);
        check("l1_rdwr_rdata_unchanged", d, 32'h0BADF00D);
        txn(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, lat, d, ra);
        check("l1_rd_after_rdwr", d, 32'h12345678);

        // LATENCY=5 instance
        txn(2, 1'b0, 1'b1, 32'h4, 32'h00000055, 4'hF, lat, d, ra);
        check("l5_wr_latency", lat, 5);
        txn(2, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, lat, d, ra);
        check("l5_rd_latency", lat, 5);
        check("l5_rd_data", d, 32'h00000055);
        check("l5_rd_pulse_width", {31'b0, ra}, 32'h0);
        txn(2, 1'b1, 1'b1, 32'h4, 32'h00000066, 4'hF, lat, d, ra);
        check("l5_rdwr_rdata_unchanged", d, 32'h00000055);
        txn(2, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, lat, d, ra);
        check("l5_rd_after_rdwr", d, 32'h00000066);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
